// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_pkg
// Purpose  : Register offsets, handshake state encoding and EVENTS bit layout
//            shared by the SoC I/O register block and its timer.
// Revision : 1.0
// ============================================================================
package soc_pkg;

    // Word offsets, i.e. mem_addr[5:2]
    localparam logic [3:0] c_reg_leds1     = 4'h0;
    localparam logic [3:0] c_reg_leds2     = 4'h1;
    localparam logic [3:0] c_reg_leds3     = 4'h2;
    localparam logic [3:0] c_reg_leds4     = 4'h3;
    localparam logic [3:0] c_reg_key_state = 4'h4;
    localparam logic [3:0] c_reg_events    = 4'h5;
    localparam logic [3:0] c_reg_timer     = 4'h6;
    localparam logic [3:0] c_reg_timer_cmp = 4'h7;
    localparam logic [3:0] c_reg_irq_en    = 4'h8;

    localparam int          c_ev_width      = 5;
    localparam int          c_ev_key_lsb    = 0;
    localparam int          c_ev_match      = 4;
    localparam logic [31:0] c_timer_cmp_rst = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2
    } io_fsm_t;

endpackage
`default_nettype wire

// File: rtl/io_timer.sv
`default_nettype none
// ============================================================================
// Module   : io_timer
// Purpose  : Free-running 32-bit TIMER with TIMER_CMP and a compare-match pulse.
// Revision : 1.0
// ============================================================================
module io_timer
    import soc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_timer,
    input  logic        i_wr_cmp,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_timer,
    output logic [31:0] o_cmp,
    output logic        o_match
);

    logic [31:0] r_timer;
    logic [31:0] r_cmp;
    logic [31:0] w_timer_nxt;
    logic [31:0] w_cmp_nxt;

    assign w_timer_nxt = i_wr_timer ? i_wdata : r_timer + 32'd1;
    assign w_cmp_nxt   = i_wr_cmp   ? i_wdata : r_cmp;

    // Compare on next-state values so the flag is already set in the cycle
    // where TIMER equals TIMER_CMP.
    assign o_match = (w_timer_nxt == w_cmp_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_cmp   <= c_timer_cmp_rst;
        end else begin
            r_timer <= w_timer_nxt;
            r_cmp   <= w_cmp_nxt;
        end
    end

    assign o_timer = r_timer;
    assign o_cmp   = r_cmp;

endmodule
`default_nettype wire

// File: rtl/soc_io_regs.sv
`default_nettype none
// ============================================================================
// Module   : soc_io_regs
// Purpose  : Memory-mapped LED, key-event, timer and interrupt registers.
// Revision : 1.0
// ============================================================================
module soc_io_regs
    import soc_pkg::*;
#(
    parameter int N_KEYS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_sel,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_wstrobe,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    input  logic [N_KEYS-1:0] key_press,
    input  logic [N_KEYS-1:0] key_state,
    output logic [7:0]        leds1,
    output logic [7:0]        leds2,
    output logic [7:0]        leds3,
    output logic [7:0]        leds4,
    output logic              irq
);

    io_fsm_t               r_state;
    logic [3:0]            r_addr;
    logic [31:0]           r_wdata;
    logic                  r_wr;
    logic                  r_done;
    logic [31:0]           r_rdata;
    logic [7:0]            r_leds1, r_leds2, r_leds3, r_leds4;
    logic [c_ev_width-1:0] r_events;
    logic [c_ev_width-1:0] r_irq_en;
    logic                  r_irq;

    logic                  w_wr_en;
    logic [31:0]           w_rd_data;
    logic [c_ev_width-1:0] w_ev_set;
    logic [c_ev_width-1:0] w_ev_clr;
    logic [31:0]           w_timer;
    logic [31:0]           w_cmp;
    logic                  w_match;
    logic                  w_unused_addr;

    assign w_unused_addr = ^{mem_addr[31:6], mem_addr[1:0]};
    assign w_wr_en       = (r_state == S_RESP) && r_wr;

    io_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_wr_timer (w_wr_en && (r_addr == c_reg_timer)),
        .i_wr_cmp   (w_wr_en && (r_addr == c_reg_timer_cmp)),
        .i_wdata    (r_wdata),
        .o_timer    (w_timer),
        .o_cmp      (w_cmp),
        .o_match    (w_match)
    );

    always_comb begin
        w_rd_data = '0;
        case (mem_addr[5:2])
            c_reg_leds1:     w_rd_data = {24'h0, r_leds1};
            c_reg_leds2:     w_rd_data = {24'h0, r_leds2};
            c_reg_leds3:     w_rd_data = {24'h0, r_leds3};
            c_reg_leds4:     w_rd_data = {24'h0, r_leds4};
            c_reg_key_state: w_rd_data = 32'(key_state);
            c_reg_events:    w_rd_data = 32'(r_events);
            c_reg_timer:     w_rd_data = w_timer;
            c_reg_timer_cmp: w_rd_data = w_cmp;
            c_reg_irq_en:    w_rd_data = 32'(r_irq_en);
            default:         w_rd_data = '0;
        endcase
    end

    always_comb begin
        w_ev_set                 = '0;
        w_ev_set[c_ev_key_lsb+:4] = 4'(key_press);
        w_ev_set[c_ev_match]     = w_match;
        w_ev_clr                 = (w_wr_en && (r_addr == c_reg_events))
                                   ? r_wdata[c_ev_width-1:0] : '0;
    end

    // One access per io_sel assertion: HOLD absorbs the remainder of the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done  <= 1'b0;
                    r_rdata <= '0;
                    if (io_sel) begin
                        r_state <= S_RESP;
                        r_addr  <= mem_addr[5:2];
                        r_wdata <= mem_wdata;
                        r_wr    <= mem_wstrobe;
                        r_done  <= 1'b1;
                        r_rdata <= mem_wstrobe ? 32'h0 : w_rd_data;
                    end
                end
                S_RESP: begin
                    r_state <= S_HOLD;
                    r_done  <= 1'b0;
                    r_rdata <= '0;
                end
                S_HOLD: begin
                    if (!io_sel) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_leds1  <= '0;
            r_leds2  <= '0;
            r_leds3  <= '0;
            r_leds4  <= '0;
            r_irq_en <= '0;
            r_events <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                case (r_addr)
                    c_reg_leds1:  r_leds1  <= r_wdata[7:0];
                    c_reg_leds2:  r_leds2  <= r_wdata[7:0];
                    c_reg_leds3:  r_leds3  <= r_wdata[7:0];
                    c_reg_leds4:  r_leds4  <= r_wdata[7:0];
                    c_reg_irq_en: r_irq_en <= r_wdata[c_ev_width-1:0];
                    default: ;
                endcase
            end
            // Set after clear so a simultaneous set wins.
            r_events <= (r_events & ~w_ev_clr) | w_ev_set;
            r_irq    <= |(r_events & r_irq_en);
        end
    end

    assign mem_done  = r_done;
    assign mem_rdata = r_rdata;
    assign leds1     = r_leds1;
    assign leds2     = r_leds2;
    assign leds3     = r_leds3;
    assign leds4     = r_leds4;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: doc/soc_io_regs.md
SOC_IO_REGS -- requirements
Module: soc_io_regs

Interface
REQ-001 Parameter: N_KEYS, 4, number of key inputs (1..4).
REQ-002 Ports, one per line:
- clk, input, 1, single core clock.
- rst, input, 1, asynchronous, active-high reset.
- io_sel, input, 1, address decoder selects this block.
- mem_addr, input, 32, byte address; only bits [5:2] decoded.
- mem_wdata, input, 32, write data.
- mem_wstrobe, input, 1, 1 = write, 0 = read.
- mem_rdata, output, 32, read data.
- mem_done, output, 1, transaction complete.
- key_press, input, N_KEYS, one-cycle debounced press pulses.
- key_state, input, N_KEYS, debounced key levels.
- leds1..leds4, output, 8 each, LED-scan holding registers.
- irq, output, 1, interrupt request.

Function
REQ-003 Register map, selected by mem_addr[5:2]; all other offsets are unmapped:
- 0x00..0x0C: LEDS1..LEDS4, RW, bits [7:0].
- 0x10: KEY_STATE, RO.
- 0x14: EVENTS, W1C; bits [N_KEYS-1:0] are key flags, bit 4 is the compare-match flag.
- 0x18: TIMER, RW.
- 0x1C: TIMER_CMP, RW.
- 0x20: IRQ_EN, RW, bits [4:0].
REQ-004 Handshake FSM has three states: IDLE, RESP and HOLD.
- IDLE->RESP when io_sel=1; the address, wdata and wstrobe are captured on that edge.
- RESP: mem_done=1 for exactly one cycle, and the write takes effect on the RESP->HOLD edge.
- HOLD: waits while io_sel=1, then returns to IDLE when io_sel=0.
REQ-005 mem_rdata is valid only while mem_done=1 and is 0 otherwise.
- Unmapped reads return 0; unmapped writes are ignored.
- Unused upper bits read as 0.
REQ-006 Read latency is 1 cycle from io_sel sampled high to mem_done.
- Exactly one access per io_sel assertion.
REQ-007 TIMER is a 32-bit free-running counter that increments every cycle.
- Wraps from 0xFFFFFFFF to 0x00000000.
- A write loads mem_wdata; the next cycle continues incrementing from that value.
REQ-008 Compare-match flag (EVENTS[4]) sets in any cycle where TIMER==TIMER_CMP.
- This includes the wrap boundary.
- Writing TIMER_CMP does not alter TIMER.
REQ-009 A key_press[i] pulse sets EVENTS[i]; flags are sticky until cleared.
REQ-010 EVENTS writes clear the bits written as 1; bits written as 0 are unchanged.
- If a set and a clear hit the same bit in the same cycle, the set wins.
REQ-011 irq = |(EVENTS[4:0] & IRQ_EN[4:0]), registered, so it follows the flags by 1 cycle.
REQ-012 Reading EVENTS has no side effect.

Reset
REQ-013 While rst=1, regardless of clock:
- FSM is IDLE; mem_done=0 and mem_rdata=0.
- LEDS1..LEDS4=0x00; EVENTS=0; TIMER=0.
- TIMER_CMP=0xFFFFFFFF; IRQ_EN=0; irq=0.
REQ-014 Reset asserted mid-transaction aborts it.
- No pending write is applied.
- After reset release, io_sel still high starts a new transaction from IDLE.

Structure
REQ-015 Shared package soc_pkg holds the register offset constants, the io_fsm_t state enum and the EVENTS bit indices.
REQ-016 One sub-module, io_timer, holds TIMER, TIMER_CMP and the match pulse; everything else stays in soc_io_regs.

Verification
REQ-017 Write 0xA5 to offset 0x04, then read it back.
- Expect mem_done high for exactly 1 cycle per access.
- Expect leds2=0xA5 and rdata=0x000000A5.
REQ-018 Pulse key_press[2], then read EVENTS, then write 0x4, then read again.
- Expect 0x4 on the first read and 0x0 on the second.
- Repeat with a new pulse in the same cycle as the write: expect the bit to stay 1.
REQ-019 Write TIMER=0xFFFFFFFD and TIMER_CMP=0x00000001.
- Expect TIMER to wrap to 0.
- Expect EVENTS[4] set 4 cycles after the load edge.
- With IRQ_EN=0x10, expect irq=1 one cycle after the flag.
REQ-020 Read offset 0x3C and write 0x3C.
- Expect rdata=0 and no register change.
REQ-021 Assert rst during RESP of a write of 0xFF to LEDS1.
- Expect leds1=0x00, mem_done=0 immediately, and the FSM in IDLE.
REQ-022 Hold io_sel high for 5 cycles.
- Expect exactly one mem_done pulse and exactly one applied write.
